// File: rtl/median_frame_sched.sv
// -----------------------------------------------------------------------------
// median_frame_sched
// Frame-level scheduler for one 3x3 MEDIAN datapath. It walks an IMG_W x IMG_H
// image in a source RAM in raster order. Border pixels are copied unchanged to
// the destination RAM. For each interior pixel it streams the 3x3 neighbourhood
// into MEDIAN (row-major, top-left first) and writes the returned median.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   i_START              begin a frame; only sampled in IDLE
//   o_BUSY               frame in progress
//   o_DONE               1-cycle pulse after the last destination write
//   o_ERR                sticky MEDIAN timeout flag, cleared by the next START
//   o_RD_EN/o_RD_ADDR    source RAM read port (sync RAM, i_RD_DATA 1 cycle later)
//   i_RD_DATA            source read data
//   o_WR_EN/o_WR_ADDR/o_WR_DATA   destination RAM write port
//   o_MED_DSI/o_MED_DI   MEDIAN data-valid / data in
//   i_MED_DSO/i_MED_DO   MEDIAN result strobe / result
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for START
// SELECT   | classify current pixel as border or interior
// B_RD     | read border pixel from source
// B_WR     | write border pixel (source data) to destination
// W_RD     | 9 window reads, k = 0..8
// W_LAST   | 9th datum on RD_DATA, arm watchdog
// WAIT_MED | wait for MEDIAN result, abort on watchdog terminal count
// M_WR     | write registered median to destination
// NEXT     | finish frame or advance x/y
// -----------------------------------------------------------------------------
module median_frame_sched #(
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 i_START,
    output logic                 o_BUSY,
    output logic                 o_DONE,
    output logic                 o_ERR,
    output logic                 o_RD_EN,
    output logic [ADDR_W-1:0]    o_RD_ADDR,
    input  logic [DATA_SIZE-1:0] i_RD_DATA,
    output logic                 o_WR_EN,
    output logic [ADDR_W-1:0]    o_WR_ADDR,
    output logic [DATA_SIZE-1:0] o_WR_DATA,
    output logic                 o_MED_DSI,
    output logic [DATA_SIZE-1:0] o_MED_DI,
    input  logic                 i_MED_DSO,
    input  logic [DATA_SIZE-1:0] i_MED_DO
);

    if (IMG_W < 3) begin : g_bad_w
        $error("median_frame_sched: IMG_W must be at least 3");
    end
    if (IMG_H < 3) begin : g_bad_h
        $error("median_frame_sched: IMG_H must be at least 3");
    end
    if ((2 ** ADDR_W) < IMG_W * IMG_H) begin : g_bad_a
        $error("median_frame_sched: ADDR_W too small for IMG_W*IMG_H");
    end
    if (TIMEOUT < 1) begin : g_bad_t
        $error("median_frame_sched: TIMEOUT must be at least 1");
    end

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SELECT, S_B_RD, S_B_WR, S_W_RD,
        S_W_LAST, S_WAIT_MED, S_M_WR, S_NEXT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [3:0]            r_k;
    logic [TW-1:0]         r_wd;
    logic [DATA_SIZE-1:0]  r_med;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_dsi;

    logic                  w_border;
    logic                  w_last_pix;
    logic [1:0]            w_kr;
    logic [1:0]            w_kc;
    logic [ADDR_W-1:0]     w_pix_addr;
    logic [ADDR_W-1:0]     w_win_addr;

    assign w_border   = (r_x == '0) || (r_y == '0) ||
                        (r_x == XW'(IMG_W - 1)) || (r_y == YW'(IMG_H - 1));
    assign w_last_pix = (r_x == XW'(IMG_W - 1)) && (r_y == YW'(IMG_H - 1));

    // k -> (row, col) inside the window; avoids a divider for k/3, k%3
    always_comb begin
        w_kr = 2'd0;
        w_kc = 2'd0;
        case (r_k)
            4'd0: begin w_kr = 2'd0; w_kc = 2'd0; end
            4'd1: begin w_kr = 2'd0; w_kc = 2'd1; end
            4'd2: begin w_kr = 2'd0; w_kc = 2'd2; end
            4'd3: begin w_kr = 2'd1; w_kc = 2'd0; end
            4'd4: begin w_kr = 2'd1; w_kc = 2'd1; end
            4'd5: begin w_kr = 2'd1; w_kc = 2'd2; end
            4'd6: begin w_kr = 2'd2; w_kc = 2'd0; end
            4'd7: begin w_kr = 2'd2; w_kc = 2'd1; end
            4'd8: begin w_kr = 2'd2; w_kc = 2'd2; end
            default: begin w_kr = 2'd0; w_kc = 2'd0; end
        endcase
    end

    assign w_pix_addr = ADDR_W'(r_y) * ADDR_W'(IMG_W) + ADDR_W'(r_x);

    // Only evaluated for interior pixels, so the -1 terms never wrap
    assign w_win_addr = (ADDR_W'(r_y) + ADDR_W'(w_kr) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                      + ADDR_W'(r_x) + ADDR_W'(w_kc) - ADDR_W'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_RD_EN   = 1'b0;
        o_RD_ADDR = '0;
        o_WR_EN   = 1'b0;
        o_WR_ADDR = '0;
        o_WR_DATA = '0;
        case (r_state)
            S_IDLE:     if (i_START) w_next = S_SELECT;
            S_SELECT:   w_next = w_border ? S_B_RD : S_W_RD;
            S_B_RD: begin
                o_RD_EN   = 1'b1;
                o_RD_ADDR = w_pix_addr;
                w_next    = S_B_WR;
            end
            S_B_WR: begin
                o_WR_EN   = 1'b1;
                o_WR_ADDR = w_pix_addr;
                o_WR_DATA = i_RD_DATA;
                w_next    = S_NEXT;
            end
            S_W_RD: begin
                o_RD_EN   = 1'b1;
                o_RD_ADDR = w_win_addr;
                if (r_k == 4'd8) w_next = S_W_LAST;
            end
            S_W_LAST:   w_next = S_WAIT_MED;
            S_WAIT_MED: begin
                if (i_MED_DSO)       w_next = S_M_WR;
                else if (r_wd == '0) w_next = S_IDLE;
            end
            S_M_WR: begin
                o_WR_EN   = 1'b1;
                o_WR_ADDR = w_pix_addr;
                o_WR_DATA = r_med;
                w_next    = S_NEXT;
            end
            S_NEXT:     w_next = w_last_pix ? S_IDLE : S_SELECT;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_x    <= '0;
            r_y    <= '0;
            r_k    <= '0;
            r_wd   <= '0;
            r_med  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_dsi  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // One-cycle delay aligns the valid with RD_DATA of the sync RAM
            r_dsi  <= o_RD_EN && (r_state == S_W_RD);
            case (r_state)
                S_IDLE: begin
                    if (i_START) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        r_x    <= '0;
                        r_y    <= '0;
                    end
                end
                S_SELECT: r_k <= '0;
                S_W_RD:   if (r_k != 4'd8) r_k <= r_k + 4'd1;
                // Down-counter: terminal count at 0 gives exactly TIMEOUT cycles
                S_W_LAST: r_wd <= TW'(TIMEOUT - 1);
                S_WAIT_MED: begin
                    if (i_MED_DSO) begin
                        r_med <= i_MED_DO;
                    end else if (r_wd == '0) begin
                        r_err  <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_wd <= r_wd - 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_last_pix) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else if (r_x == XW'(IMG_W - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_BUSY    = r_busy;
    assign o_DONE    = r_done;
    assign o_ERR     = r_err;
    assign o_MED_DSI = r_dsi;
    assign o_MED_DI  = i_RD_DATA;

endmodule
